// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and defaults for the APB request arbiter.
package apb_req_arbiter_pkg;

  localparam int ARB_NUM_REQ_DEF = 4;
  localparam int ARB_TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_WAIT_RESP,
    ARB_RELEASE
  } arb_states_e;

  // Request packet as presented at the head of each NI request FIFO.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        write;
  } req_packet_s;

  // Response packet pushed by the manager into the granted response FIFO.
  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
  } resp_packet_s;

endpackage

// File: rtl/apb_rr_picker.sv
// Rotating-priority encoder: returns the first set request at or after ptr_i,
// wrapping modulo NUM_REQ.
module apb_rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W:0] pos;

  // Scan offsets from highest to lowest so the smallest offset from ptr_i wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
        pos = pos - (IDX_W + 1)'(NUM_REQ);
      end
      if (req_i[pos[IDX_W-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB manager among NUM_REQ NI FIFO pairs.
// The grant is held from the request pop until the response push, or until
// the wait counter expires (e.g. slave error with no response pushed).
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter  int NUM_REQ     = ARB_NUM_REQ_DEF,
  parameter  int TIMEOUT_CYC = ARB_TIMEOUT_DEF,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [NUM_REQ-1:0] req_fifo_empty,
  input  req_packet_s        req_fifo_data [NUM_REQ],
  output logic [NUM_REQ-1:0] req_fifo_rreq,
  input  logic [NUM_REQ-1:0] resp_fifo_full,
  output logic [NUM_REQ-1:0] resp_fifo_wreq,
  output resp_packet_s       resp_fifo_data,
  output req_packet_s        mgr_trans_pkt,
  output logic               mgr_fifo_empty,
  output logic               mgr_fifo_full,
  input  logic               mgr_fifo_rreq,
  input  resp_packet_s       mgr_resp_pkt,
  input  logic               mgr_fifo_wreq,
  output logic [IDX_W-1:0]   grant_id,
  output logic               busy,
  output logic               timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  arb_states_e      state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  apb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i   (~req_fifo_empty),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // State, grant, pointer and timeout registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic and FIFO strobes; strobes are purely combinational on
  // state so an asynchronous reset removes them in the same cycle.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    tmo_cnt_d      = tmo_cnt_q;
    timeout_err_d  = 1'b0;
    req_fifo_rreq  = '0;
    resp_fifo_wreq = '0;
    resp_fifo_data = '0;
    mgr_fifo_empty = 1'b1;
    mgr_fifo_full  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        mgr_fifo_empty = 1'b0;
        if (mgr_fifo_rreq) begin
          req_fifo_rreq[grant_q] = 1'b1;
          state_d                = ARB_WAIT_RESP;
        end
      end
      ARB_WAIT_RESP: begin
        mgr_fifo_full = resp_fifo_full[grant_q];
        if (mgr_fifo_wreq) begin
          // A push on the terminal-count cycle takes priority over timeout.
          resp_fifo_wreq[grant_q] = 1'b1;
          resp_fifo_data          = mgr_resp_pkt;
          state_d                 = ARB_RELEASE;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ARB_RELEASE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ARB_RELEASE: begin
        rr_ptr_d  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        tmo_cnt_d = '0;
        state_d   = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign mgr_trans_pkt = req_fifo_data[grant_q];
  assign grant_id      = grant_q;
  assign busy          = (state_q != ARB_IDLE);
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter (NUM_REQ=4, TIMEOUT_CYC=8).
module tb_apb_req_arbiter;
  import apb_req_arbiter_pkg::*;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic [3:0]   req_fifo_empty;
  req_packet_s  req_fifo_data [4];
  logic [3:0]   req_fifo_rreq;
  logic [3:0]   resp_fifo_full;
  logic [3:0]   resp_fifo_wreq;
  resp_packet_s resp_fifo_data;
  req_packet_s  mgr_trans_pkt;
  logic         mgr_fifo_empty;
  logic         mgr_fifo_full;
  logic         mgr_fifo_rreq;
  resp_packet_s mgr_resp_pkt;
  logic         mgr_fifo_wreq;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;

  int checks   = 0;
  int failures = 0;

  apb_req_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(8)) dut (
    .PCLK           (PCLK),
    .PRESET         (PRESET),
    .req_fifo_empty (req_fifo_empty),
    .req_fifo_data  (req_fifo_data),
    .req_fifo_rreq  (req_fifo_rreq),
    .resp_fifo_full (resp_fifo_full),
    .resp_fifo_wreq (resp_fifo_wreq),
    .resp_fifo_data (resp_fifo_data),
    .mgr_trans_pkt  (mgr_trans_pkt),
    .mgr_fifo_empty (mgr_fifo_empty),
    .mgr_fifo_full  (mgr_fifo_full),
    .mgr_fifo_rreq  (mgr_fifo_rreq),
    .mgr_resp_pkt   (mgr_resp_pkt),
    .mgr_fifo_wreq  (mgr_fifo_wreq),
    .grant_id       (grant_id),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apply_reset();
    PRESET         = 1'b1;
    req_fifo_empty = 4'b1111;
    resp_fifo_full = 4'b0000;
    mgr_fifo_rreq  = 1'b0;
    mgr_fifo_wreq  = 1'b0;
    mgr_resp_pkt   = '0;
    tick();
    tick();
    PRESET = 1'b0;
  endtask

  task automatic test_reset();
    PRESET         = 1'b1;
    req_fifo_empty = 4'b0000;
    resp_fifo_full = 4'b1111;
    mgr_fifo_rreq  = 1'b1;
    mgr_fifo_wreq  = 1'b1;
    mgr_resp_pkt   = '{rdata: 32'hDEAD_BEEF, slverr: 1'b1};
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_tmo got=%0b exp=0", timeout_err); end
    checks++; if (req_fifo_rreq !== 4'b0000) begin failures++; $display("FAIL reset_rreq got=%b exp=0000", req_fifo_rreq); end
    checks++; if (resp_fifo_wreq !== 4'b0000) begin failures++; $display("FAIL reset_wreq got=%b exp=0000", resp_fifo_wreq); end
    checks++; if (mgr_fifo_empty !== 1'b1) begin failures++; $display("FAIL reset_mgr_empty got=%0b exp=1", mgr_fifo_empty); end
    checks++; if (mgr_fifo_full !== 1'b0) begin failures++; $display("FAIL reset_mgr_full got=%0b exp=0", mgr_fifo_full); end
    checks++; if (resp_fifo_data !== '0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", resp_fifo_data); end
    $display("txn reset done");
  endtask

  task automatic test_single_req();
    resp_packet_s exp_resp;
    exp_resp = '{rdata: 32'hCAFE_0002, slverr: 1'b0};
    apply_reset();
    req_fifo_empty = 4'b1011;
    tick();
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_grant got=%0d exp=2", grant_id); end
    checks++; if (mgr_fifo_empty !== 1'b0) begin failures++; $display("FAIL single_mgr_empty got=%0b exp=0", mgr_fifo_empty); end
    checks++; if (mgr_trans_pkt !== req_fifo_data[2]) begin failures++; $display("FAIL single_pkt got=%h exp=%h", mgr_trans_pkt, req_fifo_data[2]); end
    mgr_fifo_rreq = 1'b1;
    #1;
    checks++; if (req_fifo_rreq !== 4'b0100) begin failures++; $display("FAIL single_pop got=%b exp=0100", req_fifo_rreq); end
    tick();
    // Still requesting in WAIT_RESP: must be ignored.
    checks++; if (req_fifo_rreq !== 4'b0000) begin failures++; $display("FAIL single_pop_once got=%b exp=0000", req_fifo_rreq); end
    checks++; if (mgr_fifo_empty !== 1'b1) begin failures++; $display("FAIL single_wait_empty got=%0b exp=1", mgr_fifo_empty); end
    mgr_fifo_rreq  = 1'b0;
    req_fifo_empty = 4'b1111;
    mgr_resp_pkt   = exp_resp;
    mgr_fifo_wreq  = 1'b1;
    #1;
    checks++; if (resp_fifo_wreq !== 4'b0100) begin failures++; $display("FAIL single_push got=%b exp=0100", resp_fifo_wreq); end
    checks++; if (resp_fifo_data !== exp_resp) begin failures++; $display("FAIL single_resp_data got=%h exp=%h", resp_fifo_data, exp_resp); end
    tick();
    // Still pushing in RELEASE: must be ignored.
    checks++; if (resp_fifo_wreq !== 4'b0000) begin failures++; $display("FAIL single_push_once got=%b exp=0000", resp_fifo_wreq); end
    checks++; if (resp_fifo_data !== '0) begin failures++; $display("FAIL single_data_idle got=%h exp=0", resp_fifo_data); end
    mgr_fifo_wreq  = 1'b0;
    mgr_resp_pkt   = '0;
    // Ports 0 and 3 pending: with rr_ptr=3 port 3 must win.
    req_fifo_empty = 4'b0110;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_gap got=%0b exp=0", busy); end
    tick();
    checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL single_rr_ptr3 got=%0d exp=3", grant_id); end
    $display("txn single port=2 next=%0d", grant_id);
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g;
    apply_reset();
    req_fifo_empty = 4'b0000;
    for (int t = 0; t < 8; t++) begin
      exp_g = 2'(t % 4);
      tick();
      checks++; if (grant_id !== exp_g) begin failures++; $display("FAIL fair_grant_%0d got=%0d exp=%0d", t, grant_id, exp_g); end
      mgr_fifo_rreq = 1'b1;
      tick();
      mgr_fifo_rreq = 1'b0;
      mgr_fifo_wreq = 1'b1;
      mgr_resp_pkt  = '{rdata: 32'(t), slverr: 1'b0};
      tick();
      mgr_fifo_wreq = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fair_idle_%0d got=%0d exp=0", t, busy); end
      $display("txn fairness idx=%0d port=%0d", t, exp_g);
    end
  endtask

  task automatic test_timeout();
    int first_c;
    int pulses;
    first_c = 0;
    pulses  = 0;
    apply_reset();
    req_fifo_empty = 4'b1001;
    tick();
    checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL tmo_grant1 got=%0d exp=1", grant_id); end
    mgr_fifo_rreq = 1'b1;
    tick();
    mgr_fifo_rreq = 1'b0;
    // Cycle 1 is the first WAIT_RESP cycle (tmo_cnt=0); terminal count 7 is
    // cycle 8, so the registered pulse appears in cycle 9 (RELEASE).
    for (int c = 1; c <= 15; c++) begin
      if (timeout_err === 1'b1) begin
        pulses++;
        if (first_c == 0) first_c = c;
      end
      if (c != 15) tick();
    end
    checks++; if (first_c != 9) begin failures++; $display("FAIL tmo_cycle got=%0d exp=9", first_c); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL tmo_pulses got=%0d exp=1", pulses); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL tmo_next_grant got=%0d exp=2", grant_id); end
    checks++; if (mgr_fifo_empty !== 1'b0) begin failures++; $display("FAIL tmo_next_state got=%0b exp=0", mgr_fifo_empty); end
    $display("txn timeout port=1 pulse_cycle=%0d", first_c);
  endtask

  task automatic test_tie();
    resp_packet_s exp_resp;
    exp_resp = '{rdata: 32'h0000_7E57, slverr: 1'b1};
    apply_reset();
    req_fifo_empty = 4'b0111;
    tick();
    checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL tie_grant got=%0d exp=3", grant_id); end
    mgr_fifo_rreq = 1'b1;
    tick();
    mgr_fifo_rreq  = 1'b0;
    req_fifo_empty = 4'b1111;
    repeat (7) tick();
    mgr_resp_pkt  = exp_resp;
    mgr_fifo_wreq = 1'b1;
    #1;
    checks++; if (resp_fifo_wreq !== 4'b1000) begin failures++; $display("FAIL tie_push got=%b exp=1000", resp_fifo_wreq); end
    checks++; if (resp_fifo_data !== exp_resp) begin failures++; $display("FAIL tie_data got=%h exp=%h", resp_fifo_data, exp_resp); end
    tick();
    mgr_fifo_wreq = 1'b0;
    mgr_resp_pkt  = '0;
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tie_no_tmo got=%0b exp=0", timeout_err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tie_release_busy got=%0b exp=1", busy); end
    tick();
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tie_no_tmo_late got=%0b exp=0", timeout_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tie_idle got=%0b exp=0", busy); end
    $display("txn tie port=3");
  endtask

  task automatic test_reset_midop();
    apply_reset();
    // Complete one transaction on port 1 so rr_ptr moves to 2.
    req_fifo_empty = 4'b1101;
    tick();
    mgr_fifo_rreq = 1'b1;
    tick();
    mgr_fifo_rreq = 1'b0;
    mgr_fifo_wreq = 1'b1;
    tick();
    mgr_fifo_wreq  = 1'b0;
    req_fifo_empty = 4'b1011;
    tick();
    tick();
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL midop_grant got=%0d exp=2", grant_id); end
    mgr_fifo_rreq = 1'b1;
    tick();
    mgr_fifo_rreq  = 1'b0;
    resp_fifo_full = 4'b0100;
    mgr_fifo_wreq  = 1'b1;
    #1;
    checks++; if (resp_fifo_wreq !== 4'b0100) begin failures++; $display("FAIL midop_pre_push got=%b exp=0100", resp_fifo_wreq); end
    PRESET        = 1'b1;
    mgr_fifo_rreq = 1'b1;
    #1;
    checks++; if (resp_fifo_wreq !== 4'b0000) begin failures++; $display("FAIL midop_wreq got=%b exp=0000", resp_fifo_wreq); end
    checks++; if (req_fifo_rreq !== 4'b0000) begin failures++; $display("FAIL midop_rreq got=%b exp=0000", req_fifo_rreq); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midop_busy got=%0b exp=0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL midop_grant_rst got=%0d exp=0", grant_id); end
    checks++; if (mgr_fifo_full !== 1'b0) begin failures++; $display("FAIL midop_full got=%0b exp=0", mgr_fifo_full); end
    tick();
    PRESET         = 1'b0;
    mgr_fifo_rreq  = 1'b0;
    mgr_fifo_wreq  = 1'b0;
    resp_fifo_full = 4'b0000;
    req_fifo_empty = 4'b0000;
    tick();
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL midop_rr_reset got=%0d exp=0", grant_id); end
    $display("txn reset_midop port=2 aborted");
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_fifo_empty = 4'b1101;
    tick();
    resp_fifo_full = 4'b0010;
    #1;
    checks++; if (mgr_fifo_full !== 1'b0) begin failures++; $display("FAIL bp_full_grant got=%0b exp=0", mgr_fifo_full); end
    mgr_fifo_rreq = 1'b1;
    tick();
    mgr_fifo_rreq  = 1'b0;
    req_fifo_empty = 4'b1111;
    checks++; if (mgr_fifo_full !== 1'b1) begin failures++; $display("FAIL bp_full_wait got=%0b exp=1", mgr_fifo_full); end
    checks++; if (mgr_fifo_empty !== 1'b1) begin failures++; $display("FAIL bp_empty_wait got=%0b exp=1", mgr_fifo_empty); end
    resp_fifo_full = 4'b1101;
    #1;
    checks++; if (mgr_fifo_full !== 1'b0) begin failures++; $display("FAIL bp_other_port got=%0b exp=0", mgr_fifo_full); end
    resp_fifo_full = 4'b0000;
    mgr_fifo_wreq  = 1'b1;
    tick();
    mgr_fifo_wreq = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_done got=%0b exp=0", busy); end
    $display("txn backpressure port=1");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_fifo_data[i] = '{addr:  32'h4000_0000 + 32'(i * 16),
                           wdata: 32'h1111_1111 * 32'(i + 1),
                           strb:  4'hF,
                           write: 1'(i % 2)};
    end
    test_reset();
    test_single_req();
    test_fairness();
    test_timeout();
    test_tie();
    test_reset_midop();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
